// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder
//   Sequential packed-BCD adder/subtractor. It processes one decimal digit
//   per clock, least-significant digit first. Subtraction uses the ten's
//   complement of B. The registered result drives active-low
//   seven-segment codes.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   resetn  : asynchronous active-low reset
//   start   : request an operation (sampled only while idle)
//   sub     : 0 = a + b + cin, 1 = a - b
//   cin     : carry-in for add mode (ignored when subtracting)
//   a, b    : packed BCD operands, digit 0 in bits [3:0]
//   sum     : registered packed BCD result
//   cout    : registered final decimal carry (subtract: 1 = no borrow)
//   busy    : high while digits are being processed
//   done    : one-cycle completion pulse
//   err     : last accepted operand pair contained a non-BCD digit
//   hex     : active-low seven-segment codes of sum, digit i on [7i+6:7i]
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          sub_reg;
  logic          carry;

  logic          bad;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    b_eff;
  logic [4:0]    t;
  logic [4:0]    t_adj;
  logic [3:0]    digit;
  logic          c_next;

  // Any nibble above 9 in either operand makes the whole request invalid.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Single decimal digit step. In subtract mode, B is replaced by its
  // nines' complement, and the initial carry of 1 completes ten's
  // complement.
  always_comb begin
    a_dig  = a_reg[int'(idx)*4 +: 4];
    b_dig  = b_reg[int'(idx)*4 +: 4];
    b_eff  = sub_reg ? (4'd9 - b_dig) : b_dig;
    t      = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
    t_adj  = t + 5'd6;
    if (t > 5'd9) begin
      digit  = t_adj[3:0];
      c_next = 1'b1;
    end else begin
      digit  = t[3:0];
      c_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= bad;
            state   <= bad ? DONE : CALC;
          end
        end
        CALC: begin
          sum[int'(idx)*4 +: 4] <= digit;
          carry <= c_next;
          if (idx == LAST) begin
            cout  <= c_next;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_hex
    assign hex[7*g +: 7] = seg7(sum[4*g +: 4]);
  end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder
//   Directed, table-driven bench for bcd_seq_adder with DIGITS = 4.
//   Table entries hold operands and hand-computed results. Hand-written
//   sequences cover start collisions and a reset during calculation.
module tb_bcd_seq_adder;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
  logic        done;
  logic        err;
  logic [27:0] hex;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  bcd_seq_adder #(.DIGITS(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .sub    (sub),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .sum    (sum),
    .cout   (cout),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .hex    (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference seven-segment table, active low, g in bit 6
  function automatic logic [27:0] exp_hex(input logic [15:0] s);
    logic [27:0] r;
    logic [6:0]  p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (s[4*i +: 4])
        4'd0: p = 7'b1000000;
        4'd1: p = 7'b1111001;
        4'd2: p = 7'b0100100;
        4'd3: p = 7'b0110000;
        4'd4: p = 7'b0011001;
        4'd5: p = 7'b0010010;
        4'd6: p = 7'b0000010;
        4'd7: p = 7'b1111000;
        4'd8: p = 7'b0000000;
        4'd9: p = 7'b0010000;
        default: p = 7'bxxxxxxx;
      endcase
      r[7*i +: 7] = p;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Present operands and pulse start across one rising edge (edge T).
  // On return, the bench is 1 time unit into cycle T+1.
  task automatic applyStimulus(input logic s, input logic c, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    sub   = s;
    cin   = c;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input int n, input vec_t v);
    applyStimulus(v.sub, v.cin, v.a, v.b);
    if (!v.exp_err) begin
      for (int k = 1; k <= 4; k++) begin
        checkOutput($sformatf("v%0d_busy_c%0d", n, k), {30'd0, busy, done}, 32'd2);
        if (k < 4) nextCycle();
      end
      nextCycle();
    end
    checkOutput($sformatf("v%0d_done", n), {30'd0, busy, done}, 32'd1);
    checkOutput($sformatf("v%0d_sum", n), {16'd0, sum}, {16'd0, v.exp_sum});
    checkOutput($sformatf("v%0d_cout", n), {31'd0, cout}, {31'd0, v.exp_cout});
    checkOutput($sformatf("v%0d_err", n), {31'd0, err}, {31'd0, v.exp_err});
    checkOutput($sformatf("v%0d_hex", n), {4'd0, hex}, {4'd0, exp_hex(v.exp_sum)});
    nextCycle();
    checkOutput($sformatf("v%0d_idle", n), {30'd0, busy, done}, 32'd0);
    checkOutput($sformatf("v%0d_hold", n), {15'd0, err, sum}, {15'd0, v.exp_err, v.exp_sum});
  endtask

  initial begin
    int done_seen;

    vecs[0] = '{1'b0, 1'b0, 16'h0199, 16'h0001, 16'h0200, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0500, 16'h0123, 16'h0377, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0123, 16'h0500, 16'h9623, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h0001, 16'h000F, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 16'h4567, 16'h4432, 16'h9000, 1'b0, 1'b0};

    resetn = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    cin    = 1'b0;
    a      = '0;
    b      = '0;

    // Reset takes effect before any clock edge.
    #2 resetn = 1'b0;
    #1;
    checkOutput("reset_sum", {16'd0, sum}, 32'd0);
    checkOutput("reset_flags", {28'd0, cout, busy, done, err}, 32'd0);
    checkOutput("reset_hex", {4'd0, hex}, {4'd0, {4{7'b1000000}}});
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    nextCycle();
    checkOutput("idle_after_reset", {29'd0, busy, done, err}, 32'd0);

    for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

    // A start pulse in cycle T+2 must be ignored.
    applyStimulus(1'b0, 1'b0, 16'h0199, 16'h0001);
    nextCycle();
    a     = 16'h9999;
    b     = 16'h9999;
    sub   = 1'b1;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkOutput("coll_busy_t3", {30'd0, busy, done}, 32'd2);
    nextCycle();
    checkOutput("coll_busy_t4", {30'd0, busy, done}, 32'd2);
    nextCycle();
    checkOutput("coll_done_t5", {30'd0, busy, done}, 32'd1);
    checkOutput("coll_sum", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0200});
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      if (done || busy) done_seen++;
    end
    checkOutput("coll_no_requeue", done_seen, 0);

    // Reset asserted in cycle T+2 clears outputs and suppresses done.
    applyStimulus(1'b0, 1'b0, 16'h1234, 16'h1111);
    nextCycle();
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset_out", {12'd0, cout, busy, done, err, sum}, 32'd0);
    checkOutput("midreset_hex", {4'd0, hex}, {4'd0, {4{7'b1000000}}});
    @(negedge clk);
    resetn = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      if (done || busy) done_seen++;
    end
    checkOutput("midreset_no_done", done_seen, 0);
    checkOutput("midreset_sum_held", {16'd0, sum}, 32'd0);

    // A fresh operation after the aborted one behaves normally.
    runVector(100, vecs[6]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
